axi_lite_traffic_gen: RTL and testbench

AXI_LITE_TRAFFIC_GEN -- requirements
Module: axi_lite_traffic_gen
Interface
REQ-001 SHALL have parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h40000000, address of transaction 0.
REQ-002 SHALL have parameter C_M_START_DATA_VALUE, default 32'hAA000000, increment start value / LFSR seed.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width (32 or 64).
REQ-005 SHALL have parameter C_M_TRANSACTIONS_NUM, default 4, transactions per pass (1..65535).
REQ-006 SHALL have parameter C_M_ADDR_STRIDE, default 4, byte step between transaction addresses.
REQ-007 SHALL have M_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-009 SHALL have INIT_AXI_TXN  in  1  start request, rising-edge sensitive.
REQ-010 SHALL have MODE  in  3  [1:0] op: 0 write+readback, 1 write-only, 2 read-compare-only, 3 continuous loop; [2] pattern: 0 increment, 1 LFSR.
REQ-011 SHALL have TXN_DONE  out  1  one-cycle pulse at end of each pass.
REQ-012 SHALL have ERROR  out  1  sticky error flag.
REQ-013 SHALL have ERR_COUNT  out  16  saturating error count.
REQ-014 SHALL have M_AXI_AW_ADDR out ADDR_WIDTH, M_AXI_AW_PROT out 3, M_AXI_AW_VALID out 1, M_AXI_AW_READY in 1: write-address channel.
REQ-015 SHALL have M_AXI_W_DATA out DATA_WIDTH, M_AXI_W_STRB out DATA_WIDTH/8, M_AXI_W_VALID out 1, M_AXI_W_READY in 1: write-data channel.
REQ-016 SHALL have M_AXI_B_RESP in 2, M_AXI_B_VALID in 1, M_AXI_B_READY out 1: write-response channel.
REQ-017 SHALL have M_AXI_AR_ADDR out ADDR_WIDTH, M_AXI_AR_PROT out 3, M_AXI_AR_VALID out 1, M_AXI_AR_READY in 1: read-address channel.
REQ-018 SHALL have M_AXI_R_DATA in DATA_WIDTH, M_AXI_R_RESP in 2, M_AXI_R_VALID in 1, M_AXI_R_READY out 1: read-data channel.
Function
REQ-019 SHALL run FSM IDLE->WRITE->READ->DONE; op1 skips READ, op2 skips WRITE; DONE->IDLE next cycle, except op3: DONE->WRITE, looping until MODE[1:0]!=3 is sampled in DONE.
REQ-020 SHALL start only on a registered 0->1 edge of INIT_AXI_TXN seen in IDLE; edges outside IDLE ignored; MODE latched at start and at each loop restart.
REQ-021 SHALL address transaction i at BASE + i*STRIDE, modulo 2^ADDR_WIDTH (wrap silently); AW_PROT=AR_PROT=3'b000, W_STRB all ones.
REQ-022 SHALL generate data i as START+i (mod 2^DATA_WIDTH) or as a maximal-length Galois LFSR seeded with START (seed 0 replaced by 1), advanced once per transaction; the pattern restarts at the beginning of WRITE and of READ so readback expectations match.
REQ-023 SHALL keep one transaction outstanding per phase: AW_VALID and W_VALID rise together, each falls on its own ready (either order or same cycle); B_READY high until B handshake; next write starts the cycle after B handshake.
REQ-024 SHALL hold AR_VALID until AR_READY, then R_READY high until R handshake; next read starts the cycle after; no VALID drops without handshake.
REQ-025 SHALL count one error per B_RESP!=0, R_RESP!=0, or R_DATA!=expected (resp error and mismatch on one beat count 2); ERR_COUNT saturates at 16'hFFFF; ERROR=(ERR_COUNT!=0); both clear at each INIT-triggered start, not at loop restarts.
REQ-026 SHALL pulse TXN_DONE for exactly one cycle on entering DONE, once per pass.
Reset
REQ-027 SHALL, on ARESETN low (any state, mid-handshake included), immediately drive all VALID/READY outputs, TXN_DONE, ERROR, ERR_COUNT, addresses and data to 0, FSM to IDLE, with no TXN_DONE for the aborted pass; edge detector resets to 0, so INIT held high through reset release does not start a pass.
Structure
REQ-028 SHALL place FSM state encoding, MODE op/pattern encodings and LFSR tap constants in shared package axi_lite_tg_pkg.
REQ-029 SHALL instantiate one sub-module axi_lite_pattern_gen (restart/advance inputs, current-value output) for data generation.
Verification
REQ-030 SHALL cover: MODE=0, N=4, zero-wait slave -> writes AA000000..AA000003 to 40000000..4000000C, readback matches, one TXN_DONE, ERR_COUNT=0.
REQ-031 SHALL cover: random AW_READY/W_READY skew incl. W before AW -> no VALID drop before handshake, identical data/address sequence.
REQ-032 SHALL cover: slave corrupts read 2 and returns RRESP=2'b10 on read 3 -> ERR_COUNT=2, ERROR=1 at TXN_DONE.
REQ-033 SHALL cover: MODE=3'b111 for 3 passes then MODE=0 -> 3 TXN_DONE pulses, LFSR sequence repeats each pass, FSM returns to IDLE.
REQ-034 SHALL cover: ARESETN low mid-WRITE with AW_VALID high -> all outputs 0 next edge, no TXN_DONE; BASE=FFFFFFF8, STRIDE=4, N=4 -> addresses wrap to 00000000, 00000004.

---
 rtl/axi_lite_tg_pkg.sv | 35 +++
 rtl/axi_lite_pattern_gen.sv | 50 +++++
 rtl/axi_lite_traffic_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_lite_traffic_gen.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_tg_pkg.sv
// Shared definitions for the AXI4-Lite traffic generator.
// Holds the FSM state encoding, the MODE op/pattern encodings and the Galois
// LFSR tap masks (right-shifting form, one mask per supported data width).
package axi_lite_tg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDone
  } tg_state_e;

  typedef enum logic [1:0] {
    OpWriteRead = 2'd0,
    OpWriteOnly = 2'd1,
    OpReadOnly  = 2'd2,
    OpLoop      = 2'd3
  } tg_op_e;

  typedef enum logic {
    PatIncr = 1'b0,
    PatLfsr = 1'b1
  } tg_pat_e;

  // Bit layout matches the MODE input: [2] pattern, [1:0] op.
  typedef struct packed {
    tg_pat_e pattern;
    tg_op_e  op;
  } tg_mode_t;

  // Maximal-length polynomials: x^32+x^22+x^2+x+1 and x^64+x^63+x^61+x^60+1.
  localparam logic [31:0] LfsrTaps32 = 32'h8020_0003;
  localparam logic [63:0] LfsrTaps64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/axi_lite_pattern_gen.sv
// Data pattern source for the traffic generator.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (value clears to 0)
//   restart_i      reload the first value of the pattern (wins over advance_i)
//   advance_i      step to the next value
//   lfsr_i         0: incrementing pattern, 1: Galois LFSR pattern
//   value_o        current pattern value
module axi_lite_pattern_gen
  import axi_lite_tg_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter logic [31:0] StartValue = 32'hAA00_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 restart_i,
  input  logic                 advance_i,
  input  logic                 lfsr_i,
  output logic [DataWidth-1:0] value_o
);

  localparam logic [DataWidth-1:0] Taps =
      (DataWidth == 64) ? DataWidth'(LfsrTaps64) : DataWidth'(LfsrTaps32);
  localparam logic [DataWidth-1:0] Start = DataWidth'(StartValue);
  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  localparam logic [DataWidth-1:0] Seed = (Start == '0) ? DataWidth'(1) : Start;

  logic [DataWidth-1:0] value_q, value_d, lfsr_next;

  always_comb begin
    lfsr_next = (value_q >> 1) ^ (value_q[0] ? Taps : '0);
    value_d   = value_q;
    if (restart_i) begin
      value_d = lfsr_i ? Seed : Start;
    end else if (advance_i) begin
      value_d = lfsr_i ? lfsr_next : value_q + DataWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/axi_lite_traffic_gen.sv
// AXI4-Lite master traffic generator.
// On a rising edge of INIT_AXI_TXN (seen in idle) runs one pass of
// C_M_TRANSACTIONS_NUM writes and/or read-compares at BASE + i*STRIDE, with
// incrementing or LFSR data, one transaction outstanding at a time.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   INIT_AXI_TXN, MODE          start request, operation/pattern select
//   TXN_DONE, ERROR, ERR_COUNT  end-of-pass pulse, sticky error, error count
//   M_AXI_AW/W/B/AR/R_*         AXI4-Lite master channels
module axi_lite_traffic_gen
  import axi_lite_tg_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000,
  parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH         = 32,
  parameter int unsigned C_M_TRANSACTIONS_NUM       = 4,
  parameter int unsigned C_M_ADDR_STRIDE            = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [2:0]                      MODE,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [15:0]                     ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AW_ADDR,
  output logic [2:0]                      M_AXI_AW_PROT,
  output logic                            M_AXI_AW_VALID,
  input  logic                            M_AXI_AW_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_W_DATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_W_STRB,
  output logic                            M_AXI_W_VALID,
  input  logic                            M_AXI_W_READY,
  input  logic [1:0]                      M_AXI_B_RESP,
  input  logic                            M_AXI_B_VALID,
  output logic                            M_AXI_B_READY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AR_ADDR,
  output logic [2:0]                      M_AXI_AR_PROT,
  output logic                            M_AXI_AR_VALID,
  input  logic                            M_AXI_AR_READY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_R_DATA,
  input  logic [1:0]                      M_AXI_R_RESP,
  input  logic                            M_AXI_R_VALID,
  output logic                            M_AXI_R_READY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] Base    = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0] Stride  = AW'(C_M_ADDR_STRIDE);
  localparam logic [15:0]   LastIdx = 16'(C_M_TRANSACTIONS_NUM - 1);

  tg_state_e     state_q, state_d;
  tg_mode_t      mode_q, mode_d;
  logic          init_q, armed_q, start_q;
  logic [15:0]   idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic          ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic          done_q, done_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [16:0]   err_sum;
  logic [1:0]    err_add;
  logic          clr_err, pat_restart, pat_advance;
  logic [DW-1:0] pat_value;

  axi_lite_pattern_gen #(
    .DataWidth (DW),
    .StartValue(C_M_START_DATA_VALUE)
  ) u_pattern_gen (
    .clk_i    (M_AXI_ACLK),
    .rst_ni   (M_AXI_ARESETN),
    .restart_i(pat_restart),
    .advance_i(pat_advance),
    // mode_d so a restart uses the pattern being latched in the same cycle
    .lfsr_i   (mode_d.pattern == PatLfsr),
    .value_o  (pat_value)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    done_d      = 1'b0;
    err_add     = 2'd0;
    clr_err     = 1'b0;
    pat_restart = 1'b0;
    pat_advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          mode_d      = tg_mode_t'(MODE);
          clr_err     = 1'b1;
          idx_d       = '0;
          addr_d      = Base;
          pat_restart = 1'b1;
          if (mode_d.op == OpReadOnly) begin
            state_d    = StRead;
            ar_valid_d = 1'b1;
          end else begin
            state_d    = StWrite;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            b_ready_d  = 1'b1;
          end
        end
      end

      StWrite: begin
        if (aw_valid_q && M_AXI_AW_READY) aw_valid_d = 1'b0;
        if (w_valid_q && M_AXI_W_READY) w_valid_d = 1'b0;
        if (b_ready_q && M_AXI_B_VALID) begin
          b_ready_d   = 1'b0;
          err_add     = 2'(M_AXI_B_RESP != 2'b00);
          pat_advance = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d  = '0;
            addr_d = Base;
            if (mode_q.op == OpWriteOnly) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d     = StRead;
              pat_restart = 1'b1;
              ar_valid_d  = 1'b1;
            end
          end else begin
            idx_d      = idx_q + 16'd1;
            addr_d     = addr_q + Stride;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            b_ready_d  = 1'b1;
          end
        end
      end

      StRead: begin
        if (ar_valid_q && M_AXI_AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
        if (r_ready_q && M_AXI_R_VALID) begin
          r_ready_d   = 1'b0;
          // A bad response and a data mismatch on the same beat count twice.
          err_add     = 2'(M_AXI_R_RESP != 2'b00) + 2'(M_AXI_R_DATA != pat_value);
          pat_advance = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            addr_d  = Base;
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_q + 16'd1;
            addr_d     = addr_q + Stride;
            ar_valid_d = 1'b1;
          end
        end
      end

      StDone: begin
        if (mode_q.op == OpLoop && tg_op_e'(MODE[1:0]) == OpLoop) begin
          // Loop restart: relatch MODE but keep the error count running.
          mode_d      = tg_mode_t'(MODE);
          state_d     = StWrite;
          pat_restart = 1'b1;
          aw_valid_d  = 1'b1;
          w_valid_d   = 1'b1;
          b_ready_d   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    err_sum = {1'b0, err_cnt_q} + 17'(err_add);
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_sum[16]) begin
      err_cnt_d = 16'hFFFF;
    end else begin
      err_cnt_d = err_sum[15:0];
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= StIdle;
      mode_q     <= '{pattern: PatIncr, op: OpWriteRead};
      init_q     <= 1'b0;
      armed_q    <= 1'b0;
      start_q    <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      init_q     <= INIT_AXI_TXN;
      // INIT must be seen low after reset before a rising edge can count.
      armed_q    <= armed_q | ~INIT_AXI_TXN;
      start_q    <= INIT_AXI_TXN & ~init_q & armed_q;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign TXN_DONE       = done_q;
  assign ERR_COUNT      = err_cnt_q;
  assign ERROR          = (err_cnt_q != 16'h0);
  assign M_AXI_AW_ADDR  = addr_q;
  assign M_AXI_AW_PROT  = 3'b000;
  assign M_AXI_AW_VALID = aw_valid_q;
  assign M_AXI_W_DATA   = pat_value;
  assign M_AXI_W_STRB   = '1;
  assign M_AXI_W_VALID  = w_valid_q;
  assign M_AXI_B_READY  = b_ready_q;
  assign M_AXI_AR_ADDR  = addr_q;
  assign M_AXI_AR_PROT  = 3'b000;
  assign M_AXI_AR_VALID = ar_valid_q;
  assign M_AXI_R_READY  = r_ready_q;

endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// Testbench for axi_lite_traffic_gen: a reactive AXI4-Lite slave with memory,
// optional random ready skew and read fault injection, plus a second instance
// whose base address wraps past the top of the address space.
module tb_axi_lite_traffic_gen;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n, init;
  logic [2:0]  mode;
  logic        txn_done, error;
  logic [15:0] err_count;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0]  aw_prot, ar_prot;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;

  logic        x_init, x_done, x_error;
  logic [2:0]  x_mode;
  logic [15:0] x_err_count;
  logic [31:0] x_aw_addr, x_w_data, x_ar_addr;
  logic [2:0]  x_aw_prot, x_ar_prot;
  logic [3:0]  x_w_strb;
  logic        x_aw_valid, x_w_valid, x_b_valid, x_b_ready, x_ar_valid, x_r_valid, x_r_ready;

  always #5 clk = ~clk;

  axi_lite_traffic_gen u_dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init), .MODE(mode),
    .TXN_DONE(txn_done), .ERROR(error), .ERR_COUNT(err_count),
    .M_AXI_AW_ADDR(aw_addr), .M_AXI_AW_PROT(aw_prot), .M_AXI_AW_VALID(aw_valid),
    .M_AXI_AW_READY(aw_ready), .M_AXI_W_DATA(w_data), .M_AXI_W_STRB(w_strb),
    .M_AXI_W_VALID(w_valid), .M_AXI_W_READY(w_ready), .M_AXI_B_RESP(b_resp),
    .M_AXI_B_VALID(b_valid), .M_AXI_B_READY(b_ready), .M_AXI_AR_ADDR(ar_addr),
    .M_AXI_AR_PROT(ar_prot), .M_AXI_AR_VALID(ar_valid), .M_AXI_AR_READY(ar_ready),
    .M_AXI_R_DATA(r_data), .M_AXI_R_RESP(r_resp), .M_AXI_R_VALID(r_valid),
    .M_AXI_R_READY(r_ready)
  );

  axi_lite_traffic_gen #(
    .C_M_TARGET_SLAVE_BASE_ADDR(32'hFFFF_FFF8)
  ) u_wrap (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(x_init), .MODE(x_mode),
    .TXN_DONE(x_done), .ERROR(x_error), .ERR_COUNT(x_err_count),
    .M_AXI_AW_ADDR(x_aw_addr), .M_AXI_AW_PROT(x_aw_prot), .M_AXI_AW_VALID(x_aw_valid),
    .M_AXI_AW_READY(1'b1), .M_AXI_W_DATA(x_w_data), .M_AXI_W_STRB(x_w_strb),
    .M_AXI_W_VALID(x_w_valid), .M_AXI_W_READY(1'b1), .M_AXI_B_RESP(2'b00),
    .M_AXI_B_VALID(x_b_valid), .M_AXI_B_READY(x_b_ready), .M_AXI_AR_ADDR(x_ar_addr),
    .M_AXI_AR_PROT(x_ar_prot), .M_AXI_AR_VALID(x_ar_valid), .M_AXI_AR_READY(1'b1),
    .M_AXI_R_DATA(32'h0), .M_AXI_R_RESP(2'b00), .M_AXI_R_VALID(x_r_valid),
    .M_AXI_R_READY(x_r_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expectations pushed at stimulus time, observations by the slave.
  txn_t        exp_wr_q[$], exp_rd_q[$];
  logic [31:0] obs_aw_q[$], obs_w_q[$], obs_ar_q[$], x_obs_aw_q[$];
  logic [31:0] mem [logic [31:0]];

  bit          skew_en = 1'b0;
  int          corrupt_idx = -1, resp_err_idx = -1, rd_cnt = 0;
  int          done_cnt = 0, x_done_cnt = 0, viol = 0;
  logic [15:0] last_err = 16'h0;
  logic        last_error = 1'b0;

  // Main slave: decides this cycle's inputs at the falling edge; a handshake
  // seen here completes at the following rising edge.
  initial begin : slave
    bit          b_pend, r_pend, got_aw, got_w, prev_done;
    bit          p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_br, p_b_hs, p_rr, p_r_hs;
    logic [31:0] aw_cap, w_cap, r_data_pend, p_aw_addr, p_w_data, p_ar_addr;
    logic [1:0]  r_resp_pend;
    {aw_ready, w_ready, ar_ready, b_valid, r_valid} = '0;
    b_resp = 2'b00; r_resp = 2'b00; r_data = '0;
    {b_pend, r_pend, got_aw, got_w, prev_done} = '0;
    {p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_br, p_b_hs, p_rr, p_r_hs} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_ready, w_ready, ar_ready, b_valid, r_valid} = '0;
        {b_pend, r_pend, got_aw, got_w, prev_done} = '0;
        {p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_br, p_b_hs, p_rr, p_r_hs} = '0;
        continue;
      end
      aw_ready = skew_en ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready  = skew_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_ready = skew_en ? 1'($urandom_range(0, 1)) : 1'b1;
      b_valid  = b_pend;
      r_valid  = r_pend;
      r_data   = r_data_pend;
      r_resp   = r_resp_pend;
      // A VALID/READY that was up without handshake must stay up and stable.
      if (p_awv && !p_aw_hs && (!aw_valid || aw_addr !== p_aw_addr)) viol++;
      if (p_wv && !p_w_hs && (!w_valid || w_data !== p_w_data)) viol++;
      if (p_arv && !p_ar_hs && (!ar_valid || ar_addr !== p_ar_addr)) viol++;
      if (p_br && !p_b_hs && !b_ready) viol++;
      if (p_rr && !p_r_hs && !r_ready) viol++;
      if (prev_done && txn_done) viol++;
      p_awv = aw_valid; p_aw_hs = aw_valid && aw_ready; p_aw_addr = aw_addr;
      p_wv = w_valid; p_w_hs = w_valid && w_ready; p_w_data = w_data;
      p_arv = ar_valid; p_ar_hs = ar_valid && ar_ready; p_ar_addr = ar_addr;
      p_br = b_ready; p_b_hs = b_valid && b_ready;
      p_rr = r_ready; p_r_hs = r_valid && r_ready;
      prev_done = txn_done;
      if (txn_done) begin
        done_cnt++;
        last_err = err_count;
        last_error = error;
      end
      if (b_valid && b_ready) b_pend = 1'b0;
      if (aw_valid && aw_ready) begin obs_aw_q.push_back(aw_addr); aw_cap = aw_addr; got_aw = 1; end
      if (w_valid && w_ready) begin obs_w_q.push_back(w_data); w_cap = w_data; got_w = 1; end
      if (got_aw && got_w) begin
        mem[aw_cap] = w_cap;
        b_pend = 1'b1;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end
      if (r_valid && r_ready) r_pend = 1'b0;
      if (ar_valid && ar_ready) begin
        obs_ar_q.push_back(ar_addr);
        r_data_pend = mem.exists(ar_addr) ? mem[ar_addr] : 32'h0;
        if (rd_cnt == corrupt_idx) r_data_pend = r_data_pend ^ 32'h1;
        r_resp_pend = (rd_cnt == resp_err_idx) ? 2'b10 : 2'b00;
        rd_cnt++;
        r_pend = 1'b1;
      end
    end
  end

  // Always-ready slave for the wrapping instance.
  initial begin : wrap_slave
    bit b_pend, r_pend;
    {x_b_valid, x_r_valid, b_pend, r_pend} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {x_b_valid, x_r_valid, b_pend, r_pend} = '0;
        continue;
      end
      x_b_valid = b_pend;
      x_r_valid = r_pend;
      if (x_done) x_done_cnt++;
      if (x_b_valid && x_b_ready) b_pend = 1'b0;
      if (x_aw_valid && x_w_valid) begin x_obs_aw_q.push_back(x_aw_addr); b_pend = 1'b1; end
      if (x_r_valid && x_r_ready) r_pend = 1'b0;
      if (x_ar_valid) r_pend = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input bit lfsr, input int i);
    logic [31:0] v;
    v = 32'hAA00_0000;
    for (int k = 0; k < i; k++) v = lfsr ? ((v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0)) : v + 1;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_init();
    init = 1'b1; cyc(2); init = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 3000 && done_cnt < target; k++) cyc(1);
  endtask

  task automatic push_pass(input bit lfsr, input bit wr, input bit rd);
    txn_t t;
    for (int i = 0; i < 4; i++) begin
      t.addr = 32'h4000_0000 + 32'(i * 4);
      t.data = exp_data(lfsr, i);
      if (wr) exp_wr_q.push_back(t);
      if (rd) exp_rd_q.push_back(t);
    end
  endtask

  task automatic clear_obs();
    obs_aw_q.delete(); obs_w_q.delete(); obs_ar_q.delete();
    exp_wr_q.delete(); exp_rd_q.delete(); rd_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init = 1'b1; mode = 3'b000; x_init = 1'b0; x_mode = 3'b001;
    cyc(3);
    n_checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, txn_done, error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, txn_done, error});
    end
    n_checks++;
    if ({err_count, aw_addr, w_data} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h, expected 0", {err_count, aw_addr, w_data});
    end
    rst_n = 1'b1;
    cyc(20);
    n_checks++;
    if (obs_aw_q.size() + obs_ar_q.size() + done_cnt !== 0) begin
      n_fail++;
      $display("FAIL init_held_through_reset: got %0d transfers, expected 0",
               obs_aw_q.size() + obs_ar_q.size() + done_cnt);
    end
    init = 1'b0;
    cyc(3);
  endtask

  // Full write + readback pass; with skew the slave readies toggle randomly.
  task automatic test_traffic(input bit skew, input string name);
    txn_t        e;
    logic [31:0] a, d;
    int          d0, v0;
    clear_obs();
    skew_en = skew; d0 = done_cnt; v0 = viol; mode = 3'b000;
    push_pass(1'b0, 1'b1, 1'b1);
    pulse_init();
    wait_done(d0 + 1);
    cyc(10);
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - d0);
    end
    n_checks++;
    if (obs_aw_q.size() !== 4 || obs_w_q.size() !== 4 || obs_ar_q.size() !== 4) begin
      n_fail++;
      $display("FAIL %s beat_counts: got %0d/%0d/%0d, expected 4/4/4", name,
               obs_aw_q.size(), obs_w_q.size(), obs_ar_q.size());
    end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      a = 32'hx; d = 32'hx;
      if (obs_aw_q.size() > 0) a = obs_aw_q.pop_front();
      if (obs_w_q.size() > 0) d = obs_w_q.pop_front();
      n_checks += 2;
      if (a !== e.addr) begin n_fail++; $display("FAIL %s aw_addr: got %h, expected %h", name, a, e.addr); end
      if (d !== e.data) begin n_fail++; $display("FAIL %s w_data: got %h, expected %h", name, d, e.data); end
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      a = 32'hx;
      if (obs_ar_q.size() > 0) a = obs_ar_q.pop_front();
      n_checks++;
      if (a !== e.addr) begin n_fail++; $display("FAIL %s ar_addr: got %h, expected %h", name, a, e.addr); end
    end
    n_checks += 3;
    if (last_err !== 16'h0) begin n_fail++; $display("FAIL %s err_count: got %0d, expected 0", name, last_err); end
    if (viol - v0 !== 0) begin n_fail++; $display("FAIL %s protocol: got %0d violations, expected 0", name, viol - v0); end
    if ({w_strb, aw_prot, ar_prot} !== 10'b1111_000_000) begin
      n_fail++; $display("FAIL %s strb_prot: got %b, expected 1111000000", name, {w_strb, aw_prot, ar_prot});
    end
    skew_en = 1'b0;
  endtask

  task automatic test_read_errors();
    int d0;
    clear_obs();
    d0 = done_cnt; corrupt_idx = 1; resp_err_idx = 2; mode = 3'b000;
    pulse_init();
    wait_done(d0 + 1);
    cyc(5);
    corrupt_idx = -1; resp_err_idx = -1;
    n_checks += 3;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL errors done_pulses: got %0d, expected 1", done_cnt - d0); end
    if (last_err !== 16'd2) begin n_fail++; $display("FAIL errors err_count: got %0d, expected 2", last_err); end
    if (last_error !== 1'b1) begin n_fail++; $display("FAIL errors error_flag: got %b, expected 1", last_error); end
  endtask

  // Read-compare-only against memory left by the previous pass; a fresh start
  // must also clear the errors of the previous pass.
  task automatic test_read_only();
    int d0;
    clear_obs();
    d0 = done_cnt; mode = 3'b010;
    n_checks++;
    if (err_count !== 16'd2) begin n_fail++; $display("FAIL sticky err_count: got %0d, expected 2", err_count); end
    pulse_init();
    wait_done(d0 + 1);
    cyc(5);
    n_checks += 4;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL read_only done_pulses: got %0d, expected 1", done_cnt - d0); end
    if (obs_aw_q.size() !== 0) begin n_fail++; $display("FAIL read_only writes: got %0d, expected 0", obs_aw_q.size()); end
    if (obs_ar_q.size() !== 4) begin n_fail++; $display("FAIL read_only reads: got %0d, expected 4", obs_ar_q.size()); end
    if ({last_err, error} !== 17'h0) begin n_fail++; $display("FAIL read_only err_cleared: got %0d, expected 0", last_err); end
  endtask

  task automatic test_loop();
    txn_t        e;
    logic [31:0] a, d;
    int          d0;
    bit          switched;
    clear_obs();
    d0 = done_cnt; switched = 1'b0; mode = 3'b111;
    for (int p = 0; p < 3; p++) push_pass(1'b1, 1'b1, 1'b1);
    pulse_init();
    for (int k = 0; k < 5000 && done_cnt < d0 + 3; k++) begin
      cyc(1);
      if (!switched && done_cnt >= d0 + 2) begin
        cyc(1);  // let the second DONE sample MODE=3 first
        mode = 3'b000; switched = 1'b1;
      end
    end
    cyc(20);
    n_checks += 3;
    if (done_cnt - d0 !== 3) begin n_fail++; $display("FAIL loop done_pulses: got %0d, expected 3", done_cnt - d0); end
    if ({aw_valid, ar_valid} !== 2'b00) begin n_fail++; $display("FAIL loop back_to_idle: got %b, expected 00", {aw_valid, ar_valid}); end
    if (last_err !== 16'h0) begin n_fail++; $display("FAIL loop err_count: got %0d, expected 0", last_err); end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      a = 32'hx; d = 32'hx;
      if (obs_aw_q.size() > 0) a = obs_aw_q.pop_front();
      if (obs_w_q.size() > 0) d = obs_w_q.pop_front();
      n_checks += 2;
      if (a !== e.addr) begin n_fail++; $display("FAIL loop aw_addr: got %h, expected %h", a, e.addr); end
      if (d !== e.data) begin n_fail++; $display("FAIL loop lfsr_data: got %h, expected %h", d, e.data); end
    end
    n_checks++;
    if (obs_ar_q.size() !== exp_rd_q.size()) begin
      n_fail++; $display("FAIL loop reads: got %0d, expected %0d", obs_ar_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int d0;
    clear_obs();
    d0 = done_cnt; skew_en = 1'b1; mode = 3'b001;
    pulse_init();
    for (int k = 0; k < 200 && !aw_valid; k++) cyc(1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, txn_done, error, err_count, aw_addr, w_data}
        !== 87'h0) begin
      n_fail++;
      $display("FAIL reset_mid immediate: got %h, expected 0",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, txn_done, error, err_count, aw_addr, w_data});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, txn_done, aw_addr, w_data} !== 70'h0) begin
      n_fail++; $display("FAIL reset_mid next_edge: got %h, expected 0", {aw_valid, w_valid, aw_addr, w_data});
    end
    cyc(3);
    rst_n = 1'b1; skew_en = 1'b0;
    cyc(20);
    n_checks++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL reset_mid no_done: got %0d, expected %0d", done_cnt, d0); end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_a[4];
    logic [31:0] a;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    x_obs_aw_q.delete();
    x_mode = 3'b001;
    x_init = 1'b1; cyc(2); x_init = 1'b0;
    for (int k = 0; k < 500 && x_done_cnt < 1; k++) cyc(1);
    cyc(3);
    n_checks++;
    if (x_done_cnt !== 1) begin n_fail++; $display("FAIL wrap done_pulses: got %0d, expected 1", x_done_cnt); end
    for (int i = 0; i < 4; i++) begin
      a = 32'hx;
      if (x_obs_aw_q.size() > 0) a = x_obs_aw_q.pop_front();
      n_checks++;
      if (a !== exp_a[i]) begin n_fail++; $display("FAIL wrap aw_addr%0d: got %h, expected %h", i, a, exp_a[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_traffic(1'b0, "zero_wait");
    test_traffic(1'b1, "skew");
    test_read_errors();
    test_read_only();
    test_loop();
    test_reset_mid_write();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
